// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and the loader state encoding for the
//               instruction memory and its byte-stream writer.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Instruction memory geometry (word addressed)
  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 1024;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Assembles a little-endian byte stream into 32-bit words and
//               writes them sequentially into the instruction memory write
//               port. busy keeps the core away from the memory during a load.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  // Largest loadable word count: the full memory depth
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [1:0]        c_last_lane = 2'd3;

  loader_state_t     r_state;
  loader_state_t     w_next_state;

  logic [ADDR_W:0]   r_len;            // clamped word count of this load
  logic [ADDR_W-1:0] r_addr;           // address of the word being assembled
  logic [1:0]        r_byte_idx;       // next byte lane to fill
  logic [DATA_W-1:0] r_word;           // partially assembled word
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W:0]   r_words_written;

  logic [ADDR_W:0]   w_start_len;
  logic [DATA_W-1:0] w_next_word;
  logic              w_accept;
  logic              w_last_word;
  logic              w_in_load;

  // Lengths beyond the memory depth are clamped so the address never wraps
  assign w_start_len = (load_len > c_depth) ? c_depth : load_len;

  // A byte is taken whenever the source offers one while receiving
  assign w_accept    = byte_valid && (r_state == ST_RECV);

  // The word now being written is the final one of the load
  assign w_last_word = ((r_words_written + c_cnt_one) == r_len);

  // Abort only has an effect while a load is actually moving data
  assign w_in_load   = (r_state == ST_RECV) || (r_state == ST_WRITE);

  // Drop the incoming byte into its lane of the word under assembly
  always_comb begin
    w_next_word = r_word;
    w_next_word[{r_byte_idx, 3'b000} +: 8] = byte_data;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; abort overrides every other transition
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (w_start_len == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_accept && (r_byte_idx == c_last_lane)) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_next_state = w_last_word ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (abort && w_in_load) begin
      w_next_state = ST_IDLE;
    end
  end

  // Datapath: length latch, byte assembly, write staging and progress count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len           <= '0;
      r_addr          <= '0;
      r_byte_idx      <= '0;
      r_word          <= '0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_words_written <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len           <= w_start_len;
            r_addr          <= '0;
            r_byte_idx      <= '0;
            r_words_written <= '0;
          end
        end
        ST_RECV: begin
          if (abort) begin
            // Partial word is thrown away
            r_byte_idx <= '0;
          end else if (w_accept) begin
            r_word     <= w_next_word;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == c_last_lane) begin
              // Stage the completed word; the port holds it afterwards
              r_mem_addr  <= r_addr;
              r_mem_wdata <= w_next_word;
            end
          end
        end
        ST_WRITE: begin
          // The write lands on this edge even if abort is asserted
          r_words_written <= r_words_written + c_cnt_one;
          if (!w_last_word) begin
            r_addr <= r_addr + c_addr_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs are pure state decodes
  assign byte_ready    = (r_state == ST_RECV);
  assign mem_we        = (r_state == ST_WRITE);
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);

  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign words_written = r_words_written;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A word-level model of
//               the memory image is built from the byte stream and compared
//               with the writes observed on the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   load_len;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load_len      (load_len),
    .abort         (abort),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image as seen through the write port
  logic [31:0] tbmem [1024];
  int          wcnt  [1024];
  logic [7:0]  stream [$];

  // Per-load observations
  int n_we, n_done, bad_rdy, busy_cyc, last_addr, we_cyc, done_cyc;
  logic first_busy, first_ready, abort_busy;
  bit timeout;

  task automatic clear_track();
    for (int i = 0; i < 1024; i++) begin
      tbmem[i] = 'x;
      wcnt[i]  = 0;
    end
    n_we = 0; n_done = 0; bad_rdy = 0; busy_cyc = 0;
    last_addr = -1; we_cyc = -1; done_cyc = -1;
    abort_busy = 1'bx; timeout = 0;
  endtask

  // Advance one clock and record what the DUT shows during the new cycle
  task automatic tick(input int cyc);
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      tbmem[mem_addr] = mem_wdata;
      wcnt[mem_addr]++;
      n_we++;
      last_addr = int'(mem_addr);
      we_cyc = cyc;
      if (byte_ready !== 1'b0) bad_rdy++;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cyc++;
  endtask

  // Run one load, feeding bytes from stream; abort_after < 0 means no abort
  task automatic run_load(input int len, input bit rnd, input int abort_after,
                          input bit poke_start);
    int idx;
    int cyc;
    bit aborted;
    clear_track();
    start = 1'b1;
    load_len = len[AW:0];
    tick(1);
    start = 1'b0;
    first_busy = busy;
    first_ready = byte_ready;
    idx = 0;
    cyc = 1;
    aborted = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = (idx < stream.size()) ? stream[idx] : 8'($urandom);
      if (poke_start && cyc == 3) begin
        start = 1'b1;
        load_len = 7;
      end
      if (abort_after >= 0 && !aborted && idx == abort_after) begin
        abort = 1'b1;
        byte_valid = 1'b0;
        aborted = 1;
      end
      if (byte_valid && byte_ready === 1'b1) idx++;
      cyc++;
      tick(cyc);
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        abort_busy = busy;
      end
    end
    byte_valid = 1'b0;
    if (busy === 1'b1) timeout = 1;
  endtask

  // Count words of the first n that differ from the stream-derived image
  function automatic int image_mism(input int n);
    int m;
    logic [31:0] exp;
    m = 0;
    for (int i = 0; i < n; i++) begin
      exp = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
      if (tbmem[i] !== exp || wcnt[i] != 1) m++;
    end
    return m;
  endfunction

  task automatic fill_stream(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    byte_data = 8'h00; load_len = '0;
    #12;
    checks++;
    if ({busy, byte_ready, mem_we, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {busy, byte_ready, mem_we, done});
    end
    checks++;
    if ({mem_addr, mem_wdata, words_written} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h ww %0d want 0", mem_addr, mem_wdata, words_written);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    stream.delete();
    stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h20, 8'h00};
    run_load(2, 0, -1, 1);
    checks++;
    if ({first_busy, first_ready} !== 2'b11) begin
      errors++;
      $display("FAIL basic_start: busy/ready got %b want 11", {first_busy, first_ready});
    end
    checks++;
    if (tbmem[0] !== 32'h00000013 || tbmem[1] !== 32'h002000B3) begin
      errors++;
      $display("FAIL basic_words: got %h %h want 00000013 002000b3", tbmem[0], tbmem[1]);
    end
    checks++;
    if (n_we != 2 || n_done != 1 || timeout) begin
      errors++;
      $display("FAIL basic_counts: we %0d done %0d to %0d want 2 1 0", n_we, n_done, timeout);
    end
    checks++;
    if (words_written !== 11'd2) begin
      errors++;
      $display("FAIL basic_ww: got %0d want 2", words_written);
    end
    // 4 receive cycles + 1 write cycle per word, then the done cycle
    checks++;
    if (done_cyc != 11 || we_cyc != 10 || busy_cyc != 11) begin
      errors++;
      $display("FAIL basic_timing: done %0d we %0d busy %0d want 11 10 11", done_cyc, we_cyc, busy_cyc);
    end
  endtask

  task automatic test_zero_len();
    run_load(0, 0, -1, 0);
    checks++;
    if (n_we != 0 || n_done != 1 || done_cyc != 1 || busy_cyc != 1) begin
      errors++;
      $display("FAIL zero_len: we %0d done %0d at %0d busy %0d want 0 1 1 1", n_we, n_done, done_cyc, busy_cyc);
    end
    checks++;
    if (words_written !== 11'd0) begin
      errors++;
      $display("FAIL zero_ww: got %0d want 0", words_written);
    end
  endtask

  task automatic test_random_valid();
    int m;
    fill_stream(64);
    run_load(16, 0, -1, 0);
    m = image_mism(16);
    checks++;
    if (m != 0 || n_we != 16 || done_cyc != 81) begin
      errors++;
      $display("FAIL b2b_image: mism %0d we %0d done %0d want 0 16 81", m, n_we, done_cyc);
    end
    run_load(16, 1, -1, 0);
    m = image_mism(16);
    checks++;
    if (m != 0 || n_we != 16 || n_done != 1 || timeout) begin
      errors++;
      $display("FAIL rnd_image: mism %0d we %0d done %0d want 0 16 1", m, n_we, n_done);
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL rnd_ready_in_write: got %0d want 0", bad_rdy);
    end
  endtask

  task automatic test_clamp();
    int m;
    fill_stream(4096);
    run_load(1500, 0, -1, 0);
    m = image_mism(1024);
    checks++;
    if (n_we != 1024 || last_addr != 1023 || m != 0) begin
      errors++;
      $display("FAIL clamp_writes: we %0d last %0d mism %0d want 1024 1023 0", n_we, last_addr, m);
    end
    checks++;
    if (words_written !== 11'd1024 || n_done != 1) begin
      errors++;
      $display("FAIL clamp_ww: got %0d done %0d want 1024 1", words_written, n_done);
    end
  endtask

  task automatic test_abort();
    fill_stream(16);
    run_load(4, 0, 6, 0);
    checks++;
    if (n_we != 1 || image_mism(1) != 0 || n_done != 0) begin
      errors++;
      $display("FAIL abort_writes: we %0d done %0d w0 %h want 1 0 image ok", n_we, n_done, tbmem[0]);
    end
    checks++;
    if (abort_busy !== 1'b0 || words_written !== 11'd1) begin
      errors++;
      $display("FAIL abort_state: busy %b ww %0d want 0 1", abort_busy, words_written);
    end
  endtask

  task automatic test_rst_mid();
    int fed;
    int c;
    fill_stream(12);
    clear_track();
    start = 1'b1;
    load_len = 3;
    tick(1);
    start = 1'b0;
    fed = 0;
    c = 1;
    while (fed < 6 && c < 100) begin
      byte_valid = 1'b1;
      byte_data = stream[fed];
      if (byte_ready === 1'b1) fed++;
      c++;
      tick(c);
    end
    byte_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, byte_ready, mem_we, done} !== 4'b0000 ||
        {mem_addr, mem_wdata, words_written} !== '0) begin
      errors++;
      $display("FAIL rst_mid: ctrl %b addr %h wdata %h ww %0d want all 0",
               {busy, byte_ready, mem_we, done}, mem_addr, mem_wdata, words_written);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_stream(4);
    run_load(1, 0, -1, 0);
    checks++;
    if (image_mism(1) != 0 || last_addr != 0 || n_we != 1 || n_done != 1 ||
        words_written !== 11'd1) begin
      errors++;
      $display("FAIL rst_reload: w0 %h last %0d we %0d done %0d ww %0d want image ok 0 1 1 1",
               tbmem[0], last_addr, n_we, n_done, words_written);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_random_valid();
    test_clamp();
    test_abort();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_imem_loader
`default_nettype wire
